// File: rtl/template_match_selector_if.sv
`default_nettype none
// ============================================================================
// Module   : template_match_selector_if
// Purpose  : Accumulator snapshot inputs and match-result handshake bundle.
// Revision : 1.0
// ============================================================================
interface template_match_selector_if #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 16,
    parameter int NUM_OF_LINES  = 16,
    parameter int NUM_TEMPLATES = 4
);
    localparam int ACC_W = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int IDX_W = $clog2(NUM_TEMPLATES);

    logic             frame_done;
    logic [ACC_W-1:0] Acc_lines_sum_I_square;
    logic [ACC_W-1:0] Acc_lines_sum_I;
    logic [ACC_W-1:0] Acc_lines_sum_T_x_I_in [NUM_TEMPLATES];
    logic [ACC_W-1:0] thresh;
    logic             busy;
    logic             match_valid;
    logic             match_ready;
    logic [IDX_W-1:0] best_idx;
    logic [ACC_W-1:0] best_score;
    logic             match_found;
    logic [7:0]       overrun_cnt;

    modport master (
        output frame_done, Acc_lines_sum_I_square, Acc_lines_sum_I,
               Acc_lines_sum_T_x_I_in, thresh, match_ready,
        input  busy, match_valid, best_idx, best_score, match_found, overrun_cnt
    );

    modport slave (
        input  frame_done, Acc_lines_sum_I_square, Acc_lines_sum_I,
               Acc_lines_sum_T_x_I_in, thresh, match_ready,
        output busy, match_valid, best_idx, best_score, match_found, overrun_cnt
    );
endinterface
`default_nettype wire

// File: rtl/template_match_selector.sv
`default_nettype none
// ============================================================================
// Module   : template_match_selector
// Purpose  : Snapshots final accumulator sums on frame_done, scans templates
//            one per cycle for the highest sum T*I, presents it on valid/ready.
// Revision : 1.0
// ============================================================================
module template_match_selector #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 16,
    parameter int NUM_OF_LINES  = 16,
    parameter int NUM_TEMPLATES = 4
) (
    input  logic                          CLK,
    input  logic                          reset,
    template_match_selector_if.slave      mif
);
    localparam int ACC_W = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int IDX_W = $clog2(NUM_TEMPLATES);
    localparam int K_W   = $clog2(NUM_TEMPLATES + 1);
    localparam logic [K_W-1:0] K_END = K_W'(NUM_TEMPLATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] snap_ti [NUM_TEMPLATES];
    logic [ACC_W-1:0] snap_i2;
    logic [ACC_W-1:0] snap_thresh;
    logic [ACC_W-1:0] max_val;
    logic [IDX_W-1:0] idx;
    logic [K_W-1:0]   k;
    logic [IDX_W-1:0] k_idx;
    logic             capture;

    // Sum I travels with the bundle but plays no part in the selection.
    assign k_idx   = k[IDX_W-1:0];
    assign capture = mif.frame_done &&
                     ((state == IDLE) || ((state == DONE) && mif.match_ready));
    assign mif.busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= IDLE;
            snap_i2         <= '0;
            snap_thresh     <= '0;
            max_val         <= '0;
            idx             <= '0;
            k               <= '0;
            mif.match_valid <= 1'b0;
            mif.best_idx    <= '0;
            mif.best_score  <= '0;
            mif.match_found <= 1'b0;
            mif.overrun_cnt <= '0;
            for (int j = 0; j < NUM_TEMPLATES; j++) begin
                snap_ti[j] <= '0;
            end
        end else begin
            if (mif.frame_done && !capture && (mif.overrun_cnt != 8'hFF)) begin
                mif.overrun_cnt <= mif.overrun_cnt + 8'd1;
            end

            case (state)
                SCAN: begin
                    if (k == K_END) begin
                        mif.best_idx    <= idx;
                        mif.best_score  <= max_val;
                        mif.match_found <= (max_val >= snap_thresh) && (snap_i2 != '0);
                        mif.match_valid <= 1'b1;
                        state           <= DONE;
                    end else begin
                        // max starts at 0 so k=0 always loads; strict > keeps lower index on ties
                        if ((k == '0) || (snap_ti[k_idx] > max_val)) begin
                            max_val <= snap_ti[k_idx];
                            idx     <= k_idx;
                        end
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (mif.match_ready) begin
                        mif.match_valid <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: ;
            endcase

            // Capture overrides the DONE->IDLE transition for back-to-back frames.
            if (capture) begin
                for (int j = 0; j < NUM_TEMPLATES; j++) begin
                    snap_ti[j] <= mif.Acc_lines_sum_T_x_I_in[j];
                end
                snap_i2     <= mif.Acc_lines_sum_I_square;
                snap_thresh <= mif.thresh;
                max_val     <= '0;
                idx         <= '0;
                k           <= '0;
                state       <= SCAN;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/template_match_selector.md
Name: template_match_selector

Overview:
- Consumer at the result end of the template-matching accumulator datapath (Top).
- On each frame-done pulse, snapshots the final accumulated sums: sum I, sum I², and sum T×I for every template.
- Scans the templates sequentially and selects the best-correlating one.
- Presents index, score and match flag on a valid/ready output handshake.

Parameters:
- PIXEL_SIZE, 8, bits per pixel
- LINE_SIZE, 16, pixels per line
- NUM_OF_LINES, 16, lines accumulated per frame
- NUM_TEMPLATES, 4, templates compared in parallel upstream (≥2)
- ACC_W, $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE, accumulator width (derived; do not override)

Ports:
- CLK  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- frame_done  in  1  single-cycle pulse; accumulator inputs final this cycle
- Acc_lines_sum_I_square  in  ACC_W  accumulated sum of I²
- Acc_lines_sum_I  in  ACC_W  accumulated sum of I
- Acc_lines_sum_T_x_I_in  in  ACC_W x [NUM_TEMPLATES]  accumulated sum T×I per template
- thresh  in  ACC_W  minimum best score for a match; sampled with the snapshot
- busy  out  1  high in SCAN or DONE
- match_valid  out  1  result valid
- match_ready  in  1  downstream accepts result
- best_idx  out  $clog2(NUM_TEMPLATES)  winning template index
- best_score  out  ACC_W  winning sum T×I
- match_found  out  1  best_score ≥ thresh AND snapshot sum I² ≠ 0
- overrun_cnt  out  8  dropped frame_done pulses; saturating

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, snapshot registers 0, k=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE, frame_done=1: register all Acc inputs and thresh into the snapshot; set max=0, idx=0, k=0; go to SCAN.
- SCAN, one template per cycle:
  - If snap_TI[k] > max (strictly greater), load max=snap_TI[k] and idx=k.
  - k=0 always loads, so an all-zero frame yields idx 0, score 0.
  - Ties keep the lower index.
  - After k=NUM_TEMPLATES-1, go to DONE.
- Entering DONE: best_idx and best_score register the final idx and max; match_found is computed against the snapshot thresh and sum I².
- Latency: frame_done sampled at edge t → match_valid=1 after edge t+NUM_TEMPLATES+1.
- DONE handshake:
  - match_valid stays high and best_idx, best_score, match_found stay stable until an edge with match_ready=1.
  - On that edge: if frame_done=1 in the same cycle, snapshot and go to SCAN (back-to-back, no drop); otherwise go to IDLE.
  - match_valid deasserts on that edge. Data outputs hold their last value.
- frame_done while in SCAN, or in DONE without match_ready: pulse is dropped; overrun_cnt increments, saturating at 255. The snapshot is unaffected.
- Live Acc inputs are ignored outside the capture edge. Upstream may clear or restart its accumulators immediately after frame_done.
- Comparisons are unsigned at full ACC_W width. No truncation. match_found uses unsigned ≥.
- reset mid-SCAN or mid-DONE: returns to the reset state next edge, discards the in-flight result, clears overrun_cnt. reset dominates frame_done.
- busy = (state≠IDLE), combinational from the state register.

Test Plan (NUM_TEMPLATES=4):
- Basic select: frame_done with TI={100,900,300,50}, thresh=500, sum I²=1000, ready=1 → after 5 edges match_valid=1 for one cycle, best_idx=1, best_score=900, match_found=1.
- Tie and threshold miss: TI={700,200,700,700}, thresh=800 → best_idx=0, best_score=700, match_found=0.
- Zero energy and max values:
  - TI all 2^ACC_W−1, thresh=0, sum I²=0 → best_idx=0, match_found=0.
  - Same with sum I²=5 → match_found=1.
- Backpressure and overrun:
  - Hold ready=0 for 10 cycles after valid: outputs stay stable.
  - Pulse frame_done twice during SCAN and once during DONE → overrun_cnt=3, result unchanged.
  - ready=1 with frame_done=1 on the same edge → new SCAN starts, second result valid 5 edges later.
- Reset mid-operation: assert reset during SCAN k=2 → next edge busy=0, match_valid=0, overrun_cnt=0; a fresh frame_done then yields a correct result.
